// File: rtl/gray_decoder.sv
// ============================================================================
// Module   : gray_decoder
// Purpose  : Registered Gray-to-binary decoder with step legality checking and
//            wrap reporting. Build option GRAY_DEC_ERRCNT_EN adds ErrCount.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_decoder #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] GrayIn,
    input  logic             Clear,
    output logic [WIDTH-1:0] Binary,
    output logic             OutValid,
    output logic             Up,
    output logic             Down,
    output logic             Overflow,
    output logic             Underflow,
    output logic [CNT_W-1:0] WrapCount,
    output logic             Error,
    output logic             Locked
`ifdef GRAY_DEC_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] ErrCount
`endif
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_TRACK = 2'd1;
    localparam logic [1:0] c_ST_ERR   = 2'd2;

    localparam logic [WIDTH-1:0] c_BIN_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_BIN_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] c_BIN_ONE  = WIDTH'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_bin;
    logic             r_out_valid;
    logic             r_up;
    logic             r_down;
    logic             r_ovf;
    logic             r_unf;
    logic [CNT_W-1:0] r_wrap_cnt;
    logic             r_error;
`ifdef GRAY_DEC_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;
`endif

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_diff;

    // Binary bit i is the XOR of all Gray bits at or above position i.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_dec_bit
            assign w_bin[gi] = ^(GrayIn >> gi);
        end
    endgenerate

    // Modular step from the last accepted value; wraps naturally in WIDTH bits.
    assign w_diff = w_bin - r_bin;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= c_ST_IDLE;
            r_bin       <= c_BIN_ZERO;
            r_out_valid <= 1'b0;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_wrap_cnt  <= '0;
            r_error     <= 1'b0;
`ifdef GRAY_DEC_ERRCNT_EN
            r_err_cnt   <= '0;
`endif
        end else if (Clear) begin
            r_state     <= c_ST_IDLE;
            r_out_valid <= 1'b0;
            r_error     <= 1'b0;
        end else begin
`ifdef GRAY_DEC_ERRCNT_EN
            // Error is a single-cycle pulse in this build.
            r_error <= 1'b0;
`endif
            if (Valid) begin
                r_bin       <= w_bin;
                r_out_valid <= 1'b1;
                r_up        <= 1'b0;
                r_down      <= 1'b0;
                case (r_state)
                    c_ST_IDLE: begin
                        r_state <= c_ST_TRACK;
                    end
                    c_ST_TRACK: begin
                        if (w_diff == c_BIN_ZERO) begin
                            r_up   <= 1'b0;
                            r_down <= 1'b0;
                        end else if (w_diff == c_BIN_ONE) begin
                            r_up <= 1'b1;
                            if (r_bin == c_BIN_MAX) begin
                                r_ovf <= 1'b1;
                                if (r_wrap_cnt != c_CNT_MAX)
                                    r_wrap_cnt <= r_wrap_cnt + c_CNT_ONE;
                            end
                        end else if (w_diff == c_BIN_MAX) begin
                            r_down <= 1'b1;
                            if (r_bin == c_BIN_ZERO)
                                r_unf <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
`ifdef GRAY_DEC_ERRCNT_EN
                            // Resynchronise on the new sample and keep tracking.
                            if (r_err_cnt != c_CNT_MAX)
                                r_err_cnt <= r_err_cnt + c_CNT_ONE;
`else
                            r_state <= c_ST_ERR;
`endif
                        end
                    end
                    c_ST_ERR: begin
                        r_state <= c_ST_ERR;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign Binary    = r_bin;
    assign OutValid  = r_out_valid;
    assign Up        = r_up;
    assign Down      = r_down;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;
    assign WrapCount = r_wrap_cnt;
    assign Error     = r_error;
    assign Locked    = (r_state == c_ST_TRACK);
`ifdef GRAY_DEC_ERRCNT_EN
    assign ErrCount  = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_decoder.sv
// ============================================================================
// Module   : tb_gray_decoder
// Purpose  : Directed self-checking bench for gray_decoder (WIDTH=3, CNT_W=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_decoder;

    logic       Clk;
    logic       Reset;
    logic       Valid;
    logic [2:0] GrayIn;
    logic       Clear;
    logic [2:0] Binary;
    logic       OutValid;
    logic       Up;
    logic       Down;
    logic       Overflow;
    logic       Underflow;
    logic [7:0] WrapCount;
    logic       Error;
    logic       Locked;
`ifdef GRAY_DEC_ERRCNT_EN
    logic [7:0] ErrCount;
`endif

    // {Binary, OutValid, Up, Down, Overflow, Underflow, Error, Locked}
    logic [9:0] obs;
    assign obs = {Binary, OutValid, Up, Down, Overflow, Underflow, Error, Locked};

    int n_checks;
    int n_fail;

    gray_decoder #(.WIDTH(3), .CNT_W(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Valid     (Valid),
        .GrayIn    (GrayIn),
        .Clear     (Clear),
        .Binary    (Binary),
        .OutValid  (OutValid),
        .Up        (Up),
        .Down      (Down),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .WrapCount (WrapCount),
        .Error     (Error),
        .Locked    (Locked)
`ifdef GRAY_DEC_ERRCNT_EN
        ,
        .ErrCount  (ErrCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply one cycle of inputs and sample just after the active edge.
    task automatic drive(input logic v, input logic [2:0] g, input logic clr, input logic rst_n);
        Valid  = v;
        GrayIn = g;
        Clear  = clr;
        Reset  = rst_n;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        n_checks++;
        if (obs !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 10'b0);
        end
        n_checks++;
        if (WrapCount !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_wrapcount: got %0d expected 0", WrapCount);
        end
    endtask

    task automatic test_count_up;
        logic [2:0] gseq [9];
        logic [2:0] bexp [9];
        logic [9:0] exp;
        gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        bexp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, gseq[i], 1'b0, 1'b1);
            exp = {bexp[i], 1'b1, (i > 0) ? 1'b1 : 1'b0, 1'b0, (i == 8) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b1};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL count_up step %0d: got %b expected %b", i, obs, exp);
            end
        end
        n_checks++;
        if (WrapCount !== 8'd1) begin
            n_fail++;
            $display("FAIL count_up_wrapcount: got %0d expected 1", WrapCount);
        end
        // Idle cycle: OutValid drops, everything else holds.
        drive(1'b0, 3'b101, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_no_valid: got %b expected %b", obs, {3'd0, 7'b0101001});
        end
    endtask

    task automatic test_down_wrap;
        drive(1'b1, 3'b100, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL down_wrap: got %b expected %b", obs, {3'd7, 7'b1011101});
        end
        n_checks++;
        if (WrapCount !== 8'd1) begin
            n_fail++;
            $display("FAIL down_wrap_wrapcount: got %0d expected 1", WrapCount);
        end
    endtask

    task automatic test_illegal;
        drive(1'b0, 3'b000, 1'b1, 1'b1);
        n_checks++;
        if ({Binary, OutValid, Error, Locked} !== {3'd7, 3'b000}) begin
            n_fail++;
            $display("FAIL clear_idle: got %b expected %b", {Binary, OutValid, Error, Locked}, {3'd7, 3'b000});
        end
        drive(1'b1, 3'b001, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL relock_001: got %b expected %b", obs, {3'd1, 7'b1001101});
        end
        drive(1'b1, 3'b110, 1'b0, 1'b1);
`ifdef GRAY_DEC_ERRCNT_EN
        n_checks++;
        if (obs !== {3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_jump: got %b expected %b", obs, {3'd4, 7'b1001111});
        end
        n_checks++;
        if (ErrCount !== 8'd1) begin
            n_fail++;
            $display("FAIL illegal_errcount: got %0d expected 1", ErrCount);
        end
        drive(1'b1, 3'b111, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL after_illegal: got %b expected %b", obs, {3'd5, 7'b1101101});
        end
`else
        n_checks++;
        if (obs !== {3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_jump: got %b expected %b", obs, {3'd4, 7'b1001110});
        end
        drive(1'b1, 3'b111, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL after_illegal: got %b expected %b", obs, {3'd5, 7'b1001110});
        end
`endif
    endtask

    task automatic test_clear;
        drive(1'b1, 3'b011, 1'b1, 1'b1);
        n_checks++;
        if ({Binary, OutValid, Error, Locked} !== {3'd5, 3'b000}) begin
            n_fail++;
            $display("FAIL clear_with_valid: got %b expected %b", {Binary, OutValid, Error, Locked}, {3'd5, 3'b000});
        end
        drive(1'b1, 3'b011, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL relock_011: got %b expected %b", obs, {3'd2, 7'b1001101});
        end
        n_checks++;
        if (WrapCount !== 8'd1) begin
            n_fail++;
            $display("FAIL clear_keeps_wrapcount: got %0d expected 1", WrapCount);
        end
`ifdef GRAY_DEC_ERRCNT_EN
        n_checks++;
        if (ErrCount !== 8'd1) begin
            n_fail++;
            $display("FAIL clear_keeps_errcount: got %0d expected 1", ErrCount);
        end
`endif
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 3'b010, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL step_up_3: got %b expected %b", obs, {3'd3, 7'b1101101});
        end
        drive(1'b1, 3'b011, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL step_down_2: got %b expected %b", obs, {3'd2, 7'b1011101});
        end
        drive(1'b1, 3'b011, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL step_hold_2: got %b expected %b", obs, {3'd2, 7'b1001101});
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 3'b110, 1'b0, 1'b0);
        n_checks++;
        if (obs !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected %b", obs, 10'b0);
        end
        n_checks++;
        if (WrapCount !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_wrapcount: got %0d expected 0", WrapCount);
        end
`ifdef GRAY_DEC_ERRCNT_EN
        n_checks++;
        if (ErrCount !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_errcount: got %0d expected 0", ErrCount);
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b0;
        Valid    = 1'b0;
        GrayIn   = 3'b000;
        Clear    = 1'b0;
        test_reset();
        test_count_up();
        test_down_wrap();
        test_illegal();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
